// File: rtl/imm_ext_if.sv
// imm_ext_if: instruction-in / immediate-out handshake bundle for imm_ext_pipe
//   in_valid/in_ready/inst/ceu/tag_in         : upstream instruction channel
//   out_valid/out_ready/imm/imm_type/illegal/tag_out : downstream result channel
//   master = upstream/downstream environment, slave = the extension unit
interface imm_ext_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst;
    logic [2:0]       ceu;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm;
    logic [2:0]       imm_type;
    logic             illegal;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output in_valid, inst, ceu, tag_in, out_ready,
        input  in_ready, out_valid, imm, imm_type, illegal, tag_out
    );

    modport slave (
        input  in_valid, inst, ceu, tag_in, out_ready,
        output in_ready, out_valid, imm, imm_type, illegal, tag_out
    );
endinterface

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: pipelined RISC-V immediate extension with skid buffer and illegal counter
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : imm_ext_if.slave, instruction in / immediate out handshakes
//   clr_cnt      : synchronous clear of illegal_cnt
//   illegal_cnt  : saturating count of accepted illegal selections
module imm_ext_pipe #(
    parameter int XLEN        = 32,
    parameter int AUTO_DECODE = 1,
    parameter int TAG_W       = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    imm_ext_if.slave         bus,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);
    logic [31:0]      i;
    logic [2:0]       auto_t, typ;
    logic [XLEN-1:0]  ext;
    logic             ill, accept, fire;
    logic             out_v, out_ill, sk_v, sk_ill;
    logic [XLEN-1:0]  out_imm, sk_imm;
    logic [2:0]       out_typ, sk_typ;
    logic [TAG_W-1:0] out_tag, sk_tag;
    logic [CNT_W-1:0] cnt;

    assign i = bus.inst;

    always_comb begin
        auto_t = 3'b111;
        case (i[6:0])
            7'b0010011: auto_t = (i[14:12] == 3'b001 || i[14:12] == 3'b101) ? 3'b001 : 3'b000;
            7'b0000011, 7'b1100111, 7'b1110011: auto_t = 3'b000;
            7'b0100011: auto_t = 3'b010;
            7'b0110111, 7'b0010111: auto_t = 3'b011;
            7'b1100011: auto_t = 3'b100;
            7'b1101111: auto_t = 3'b101;
            7'b0110011, 7'b0111011: auto_t = 3'b110;
            default: auto_t = 3'b111;
        endcase
    end

    assign typ = (AUTO_DECODE != 0) ? auto_t : bus.ceu;
    assign ill = (typ == 3'b111);

    // Size-casting a signed operand to XLEN replicates inst[31] upward.
    always_comb begin
        ext = '0;
        case (typ)
            3'b000: ext = XLEN'($signed(i[31:20]));
            3'b001: ext = (XLEN == 64) ? XLEN'(i[25:20]) : XLEN'(i[24:20]);
            3'b010: ext = XLEN'($signed({i[31:25], i[11:7]}));
            3'b011: ext = XLEN'($signed({i[31:12], 12'b0}));
            3'b100: ext = XLEN'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            3'b101: ext = XLEN'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            default: ext = '0;
        endcase
    end

    assign accept = bus.in_valid && !sk_v;
    assign fire   = out_v && bus.out_ready;

    // SKID only fills when OUT is held; it refills OUT on the next fire,
    // and accept is impossible in that cycle since in_ready is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v   <= 1'b0;
            out_imm <= '0;
            out_typ <= '0;
            out_ill <= 1'b0;
            out_tag <= '0;
            sk_v    <= 1'b0;
            sk_imm  <= '0;
            sk_typ  <= '0;
            sk_ill  <= 1'b0;
            sk_tag  <= '0;
        end else if (fire && sk_v) begin
            out_imm <= sk_imm;
            out_typ <= sk_typ;
            out_ill <= sk_ill;
            out_tag <= sk_tag;
            sk_v    <= 1'b0;
        end else if (accept && (!out_v || fire)) begin
            out_v   <= 1'b1;
            out_imm <= ext;
            out_typ <= typ;
            out_ill <= ill;
            out_tag <= bus.tag_in;
        end else if (accept) begin
            sk_v    <= 1'b1;
            sk_imm  <= ext;
            sk_typ  <= typ;
            sk_ill  <= ill;
            sk_tag  <= bus.tag_in;
        end else if (fire) begin
            out_v   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr_cnt)
            cnt <= CNT_W'(accept && ill);
        else if (accept && ill && !(&cnt))
            cnt <= cnt + 1'b1;
    end

    assign bus.in_ready  = !sk_v;
    assign bus.out_valid = out_v;
    assign bus.imm       = out_imm;
    assign bus.imm_type  = out_typ;
    assign bus.illegal   = out_ill;
    assign bus.tag_out   = out_tag;
    assign illegal_cnt   = cnt;
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed + random check of imm_ext_pipe against a queue-based reference
//   a/u32 : XLEN=32, auto decode, 2-bit counter
//   b/u64 : XLEN=64, manual ceu select, 16-bit counter
module tb_imm_ext_pipe;
    typedef struct {
        logic [63:0] imm;
        logic [2:0]  t;
        logic        ill;
        logic [7:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_cnt;
    logic [1:0]  cnt32;
    logic [15:0] cnt64;
    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        q32[$];
    exp_t        q64[$];
    int          m32 = 0;
    int          m64 = 0;

    imm_ext_if #(.XLEN(32), .TAG_W(8)) a ();
    imm_ext_if #(.XLEN(64), .TAG_W(8)) b ();

    imm_ext_pipe #(.XLEN(32), .AUTO_DECODE(1), .TAG_W(8), .CNT_W(2)) u32 (
        .clk(clk), .rst_n(rst_n), .bus(a.slave), .clr_cnt(clr_cnt), .illegal_cnt(cnt32)
    );
    imm_ext_pipe #(.XLEN(64), .AUTO_DECODE(0), .TAG_W(8), .CNT_W(16)) u64 (
        .clk(clk), .rst_n(rst_n), .bus(b.slave), .clr_cnt(clr_cnt), .illegal_cnt(cnt64)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] auto_type(logic [31:0] i);
        case (i[6:0])
            7'b0010011: return (i[14:12] == 3'd1 || i[14:12] == 3'd5) ? 3'd1 : 3'd0;
            7'b0000011, 7'b1100111, 7'b1110011: return 3'd0;
            7'b0100011: return 3'd2;
            7'b0110111, 7'b0010111: return 3'd3;
            7'b1100011: return 3'd4;
            7'b1101111: return 3'd5;
            7'b0110011, 7'b0111011: return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [63:0] ref_imm(logic [31:0] i, logic [2:0] t, bit x64);
        logic [63:0] r;
        case (t)
            3'd0: r = {{52{i[31]}}, i[31:20]};
            3'd1: r = x64 ? 64'(i[25:20]) : 64'(i[24:20]);
            3'd2: r = {{52{i[31]}}, i[31:25], i[11:7]};
            3'd3: r = {{32{i[31]}}, i[31:12], 12'h000};
            3'd4: r = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd5: r = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: r = 64'd0;
        endcase
        return x64 ? r : {32'd0, r[31:0]};
    endfunction

    task automatic check_all();
        chk("u32_in_ready", 64'(a.in_ready), 64'(q32.size() < 2));
        chk("u32_out_valid", 64'(a.out_valid), 64'(q32.size() > 0));
        chk("u32_cnt", 64'(cnt32), 64'(m32));
        chk("u64_in_ready", 64'(b.in_ready), 64'(q64.size() < 2));
        chk("u64_out_valid", 64'(b.out_valid), 64'(q64.size() > 0));
        chk("u64_cnt", 64'(cnt64), 64'(m64));
        if (q32.size() > 0) begin
            chk("u32_imm", 64'(a.imm), q32[0].imm);
            chk("u32_type", 64'(a.imm_type), 64'(q32[0].t));
            chk("u32_ill", 64'(a.illegal), 64'(q32[0].ill));
            chk("u32_tag", 64'(a.tag_out), 64'(q32[0].tag));
        end
        if (q64.size() > 0) begin
            chk("u64_imm", b.imm, q64[0].imm);
            chk("u64_type", 64'(b.imm_type), 64'(q64[0].t));
            chk("u64_ill", 64'(b.illegal), 64'(q64[0].ill));
            chk("u64_tag", 64'(b.tag_out), 64'(q64[0].tag));
        end
    endtask

    // Called at a falling edge: drives one cycle of inputs, advances the
    // reference across the next rising edge, then checks at the next falling edge.
    task automatic step(bit v, logic [31:0] i, logic [2:0] c, logic [7:0] t, bit ordy, bit clr);
        bit   acc, fire, i32, i64;
        exp_t e;
        a.in_valid = v;  a.inst = i; a.ceu = c; a.tag_in = t; a.out_ready = ordy;
        b.in_valid = v;  b.inst = i; b.ceu = c; b.tag_in = t; b.out_ready = ordy;
        clr_cnt = clr;
        acc  = v && (q32.size() < 2);
        fire = ordy && (q32.size() > 0);
        if (fire) begin
            void'(q32.pop_front());
            void'(q64.pop_front());
        end
        i32 = acc && (auto_type(i) == 3'd7);
        i64 = acc && (c == 3'd7);
        if (acc) begin
            e.t = auto_type(i); e.imm = ref_imm(i, e.t, 1'b0); e.ill = (e.t == 3'd7); e.tag = t;
            q32.push_back(e);
            e.t = c; e.imm = ref_imm(i, c, 1'b1); e.ill = (c == 3'd7);
            q64.push_back(e);
        end
        m32 = clr ? int'(i32) : (i32 && m32 < 3) ? m32 + 1 : m32;
        m64 = clr ? int'(i64) : (i64 && m64 < 65535) ? m64 + 1 : m64;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(bit ordy);
        step(1'b0, 32'h0, 3'd0, 8'h0, ordy, 1'b0);
    endtask

    logic [6:0] ops[13] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h37, 7'h17,
                            7'h63, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h0B};

    initial begin
        logic [31:0] r;
        rst_n = 1'b0;
        clr_cnt = 1'b0;
        a.in_valid = 1'b0; a.inst = '0; a.ceu = '0; a.tag_in = '0; a.out_ready = 1'b0;
        b.in_valid = 1'b0; b.inst = '0; b.ceu = '0; b.tag_in = '0; b.out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 64'(a.out_valid), 64'd0);
        chk("rst_in_ready", 64'(a.in_ready), 64'd1);
        chk("rst_imm", 64'(a.imm), 64'd0);
        chk("rst_type", 64'(a.imm_type), 64'd0);
        chk("rst_ill", 64'(a.illegal), 64'd0);
        chk("rst_tag", 64'(a.tag_out), 64'd0);
        chk("rst_cnt", 64'(cnt32), 64'd0);
        chk("rst_imm64", b.imm, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 32'hFFF00093, 3'd0, 8'h01, 1'b1, 1'b0);
        chk("addi_imm", 64'(a.imm), 64'hFFFFFFFF);
        chk("addi_type", 64'(a.imm_type), 64'd0);
        chk("addi_ill", 64'(a.illegal), 64'd0);

        step(1'b1, 32'hFE112E23, 3'd2, 8'h02, 1'b1, 1'b0);
        chk("sw_imm", 64'(a.imm), 64'hFFFFFFFC);
        chk("sw_tag", 64'(a.tag_out), 64'h02);
        step(1'b1, 32'hFE000CE3, 3'd4, 8'h03, 1'b1, 1'b0);
        chk("beq_imm", 64'(a.imm), 64'hFFFFFFF8);
        chk("beq_type", 64'(a.imm_type), 64'd4);
        step(1'b1, 32'h123452B7, 3'd3, 8'h04, 1'b1, 1'b0);
        chk("lui_imm", 64'(a.imm), 64'h12345000);
        chk("lui_tag", 64'(a.tag_out), 64'h04);

        step(1'b1, 32'h01F09093, 3'd1, 8'h05, 1'b1, 1'b0);
        chk("slli_imm", 64'(a.imm), 64'h1F);
        chk("slli_type", 64'(a.imm_type), 64'd1);
        step(1'b1, 32'h800002B7, 3'd3, 8'h06, 1'b1, 1'b0);
        chk("u64_lui_imm", b.imm, 64'hFFFFFFFF80000000);
        chk("u32_lui_imm", 64'(a.imm), 64'h80000000);
        idle(1'b1);

        step(1'b1, 32'h00100093, 3'd0, 8'h11, 1'b0, 1'b0);
        step(1'b1, 32'h00200093, 3'd0, 8'h12, 1'b0, 1'b0);
        step(1'b1, 32'h00300093, 3'd0, 8'h13, 1'b0, 1'b0);
        chk("bp_in_ready", 64'(a.in_ready), 64'd0);
        chk("bp_head_tag", 64'(a.tag_out), 64'h11);
        step(1'b1, 32'h00300093, 3'd0, 8'h13, 1'b1, 1'b0);
        chk("bp_second_tag", 64'(a.tag_out), 64'h12);
        step(1'b1, 32'h00300093, 3'd0, 8'h13, 1'b1, 1'b0);
        chk("bp_third_tag", 64'(a.tag_out), 64'h13);
        chk("bp_third_imm", 64'(a.imm), 64'h3);
        idle(1'b1);
        chk("bp_drained", 64'(a.out_valid), 64'd0);

        step(1'b1, 32'h0000007F, 3'd7, 8'h21, 1'b1, 1'b0);
        chk("ill_flag", 64'(a.illegal), 64'd1);
        chk("ill_imm", 64'(a.imm), 64'd0);
        for (int k = 0; k < 4; k++)
            step(1'b1, 32'h0000007F, 3'd7, 8'(8'h22 + k), 1'b1, 1'b0);
        chk("cnt_sat", 64'(cnt32), 64'd3);
        step(1'b1, 32'h0000007F, 3'd7, 8'h30, 1'b1, 1'b1);
        chk("cnt_clr_ill", 64'(cnt32), 64'd1);
        step(1'b0, 32'h0, 3'd0, 8'h0, 1'b1, 1'b1);
        chk("cnt_clr", 64'(cnt32), 64'd0);
        step(1'b1, 32'h00000033, 3'd6, 8'h31, 1'b1, 1'b0);
        chk("r_type", 64'(a.imm_type), 64'd6);
        chk("r_ill", 64'(a.illegal), 64'd0);
        idle(1'b1);

        step(1'b1, 32'h0000007F, 3'd7, 8'h41, 1'b0, 1'b0);
        step(1'b1, 32'h0000007F, 3'd7, 8'h42, 1'b0, 1'b0);
        a.in_valid = 1'b0; b.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(a.out_valid), 64'd0);
        chk("mrst_in_ready", 64'(a.in_ready), 64'd1);
        chk("mrst_cnt", 64'(cnt32), 64'd0);
        chk("mrst_cnt64", 64'(cnt64), 64'd0);
        q32.delete(); q64.delete(); m32 = 0; m64 = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'hFFF00093, 3'd0, 8'h51, 1'b1, 1'b0);
        chk("post_rst_imm", 64'(a.imm), 64'hFFFFFFFF);
        chk("post_rst_tag", 64'(a.tag_out), 64'h51);

        for (int k = 0; k < 400; k++) begin
            r = $urandom;
            r[6:0] = ops[$urandom_range(0, 12)];
            step(1'($urandom_range(0, 3) != 0), r, 3'($urandom), 8'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Pipelined, parametrised immediate-extension unit for the RISC-V datapath, placed between instruction fetch/decode and the ALU operand mux. It takes a full 32-bit instruction word and produces a sign- or zero-extended immediate of width XLEN. The immediate type comes either from opcode decode (auto mode) or from an explicit CEU select. A one-register output stage with a skid buffer and valid/ready handshakes sustains one instruction per cycle under backpressure, and a saturating counter tracks illegal selections.

## Interface
- XLEN, 32: immediate/datapath width; legal values are 32 and 64.
- AUTO_DECODE, 1: 1 derives the type from the opcode; 0 uses the `ceu` input.
- TAG_W, 8: width of the sideband tag carried alongside each instruction.
- CNT_W, 16: width of the illegal-selection counter.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present on `inst`.
- in_ready  out  1  block can accept an instruction.
- inst  in  32  instruction word.
- ceu  in  3  type select; used only when AUTO_DECODE=0.
- tag_in  in  TAG_W  sideband tag, passed through unchanged.
- out_valid  out  1  `imm` and the other outputs hold valid data.
- out_ready  in  1  consumer accepts the output.
- imm  out  XLEN  extended immediate.
- imm_type  out  3  resolved type code.
- illegal  out  1  the resolved selection was illegal.
- tag_out  out  TAG_W  tag belonging to `imm`.
- clr_cnt  in  1  synchronous clear of `illegal_cnt`.
- illegal_cnt  out  CNT_W  saturating count of illegal selections accepted.

## Operation
- Type codes and extension rules:
  - 000 I: sext(inst[31:20]).
  - 001 SHAMT: zext(inst[24:20]) when XLEN=32; zext(inst[25:20]) when XLEN=64.
  - 010 S: sext({inst[31:25],inst[11:7]}).
  - 011 U: sext({inst[31:12],12'b0}).
  - 100 B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - 101 J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - 110 R: imm=0, illegal=0.
  - 111: imm=0, illegal=1.
- In all sign-extending cases, sext replicates inst[31] up to XLEN.
- Auto decode (AUTO_DECODE=1), by opcode inst[6:0]:
  - 0010011 with funct3 (inst[14:12]) equal to 001 or 101 → SHAMT; any other funct3 → I.
  - 0000011, 1100111, 1110011 → I.
  - 0100011 → S.
  - 0110111, 0010111 → U.
  - 1100011 → B.
  - 1101111 → J.
  - 0110011, 0111011 → R.
  - Any other opcode → 111.
- Manual mode (AUTO_DECODE=0): `imm_type` equals `ceu`. Codes 110 and 111 both produce imm=0; `illegal`=1 only for 111.
- Buffering: one output register (OUT) and one skid register (SKID). `in_ready` = !SKID.valid, driven directly from the register.
- Accept (in_valid && in_ready):
  - If OUT is empty, or OUT is being consumed this cycle → extended result is loaded into OUT.
  - Otherwise → result is loaded into SKID.
- Output fire (out_valid && out_ready) while SKID is valid → SKID moves to OUT and SKID clears. An accept cannot occur in that same cycle because in_ready=0.
- Ordering is strictly FIFO. No instruction is dropped or duplicated.
- Counter: increments on each accept whose resolved type has illegal=1, and saturates at 2^CNT_W-1.
- clr_cnt together with an illegal accept in the same cycle → counter becomes 1. clr_cnt alone → counter becomes 0.
- Reset (asynchronous, any time, including mid-transfer): OUT and SKID are emptied and any held data is discarded.
  - out_valid=0, imm=0, imm_type=000, illegal=0, tag_out=0, illegal_cnt=0.
  - in_ready=1 while reset is asserted and after it is released.

## Timing
- Latency: an instruction accepted at edge N is presented on the outputs after edge N (out_valid=1 in cycle N+1).
- Throughput: one instruction per cycle while out_ready=1.
- While out_valid=1 and out_ready=0, the outputs hold stable.
- With out_ready=0: the first accept fills OUT, the second fills SKID, and in_ready drops in the following cycle.
- After out_ready rises, in_ready returns to 1 one cycle after SKID drains.
- No combinational path from in_valid or inst to any output. in_ready depends only on registered state.

## Test plan
- ADDI: AUTO_DECODE=1, XLEN=32, inst=0xFFF00093 → next cycle imm=0xFFFFFFFF, imm_type=000, illegal=0.
- SW, BEQ, LUI back-to-back with out_ready=1:
  - 0xFE112E23 → 0xFFFFFFFC, type 010.
  - 0xFE000CE3 → 0xFFFFFFF8, type 100.
  - 0x123452B7 → 0x12345000, type 011.
  - Required: one result per cycle, in order, tags preserved.
- SLLI and XLEN=64 U-type:
  - SLLI inst=0x01F09093 → imm=0x0000001F, type 001.
  - XLEN=64, inst=0x800002B7 → imm=0xFFFFFFFF80000000.
- Backpressure: hold out_ready=0 and send tags 1, 2, 3 → only 1 and 2 are accepted and in_ready=0. Raise out_ready → outputs 1, 2, 3 in order, none lost or duplicated.
- Illegal handling:
  - AUTO_DECODE=1, opcode 0x7F → illegal=1, imm=0.
  - With CNT_W=2, send 5 illegal instructions → illegal_cnt saturates at 3.
  - clr_cnt asserted with an illegal accept in the same cycle → illegal_cnt=1.
- Reset mid-stream: with OUT and SKID both full, assert rst_n=0 → out_valid=0, in_ready=1 and illegal_cnt=0 immediately (asynchronously). After release, the next instruction is output normally.
